fetch_unit: RTL

- Program-counter and fetch stage that sits directly upstream of instruction_cache and feeds the decode stage.
- Drives the byte address into the ROM and registers the returned 16-bit instruction together with its PC.
- Presents the result to decode over a valid/ready handshake.
- Supports backpressure, branch redirect, halt detection and a delivered-instruction counter.

---
 rtl/fetch_unit_if.sv | 26 ++
 rtl/fetch_unit.sv | 96 +++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-to-ROM and fetch-to-decode signal bundle; master is the fetch unit,
// slave is the environment (ROM, branch unit, decode).
interface fetch_unit_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] counter;
    logic [DATA_WIDTH-1:0] instruction;
    logic                  redirect_valid;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_instr;
    logic [DATA_WIDTH-1:0] out_pc;
    logic                  halted;
    logic [DATA_WIDTH-1:0] fetch_count;

    modport master (
        output counter, out_valid, out_instr, out_pc, halted, fetch_count,
        input  instruction, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  counter, out_valid, out_instr, out_pc, halted, fetch_count,
        output instruction, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// PC/fetch stage: one instruction per cycle, 1-cycle latency from pc to out_valid;
// out_ready low freezes pc and the output register, redirect flushes, halt stops capture.
module fetch_unit #(
    parameter int                    DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [DATA_WIDTH-1:0] HALT_INSTR = '1
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);
    typedef enum logic {FETCH, HALTED} state_t;

    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] pc, pc_n;
    logic                  out_valid_q, out_valid_n;
    logic [DATA_WIDTH-1:0] out_instr_q, out_instr_n;
    logic [DATA_WIDTH-1:0] out_pc_q, out_pc_n;
    logic                  halted_q, halted_n;
    logic [DATA_WIDTH-1:0] count_q, count_n;
    logic                  xfer;
    logic                  capture;

    assign xfer    = out_valid_q && bus.out_ready;
    assign capture = (state == FETCH) && (!out_valid_q || bus.out_ready);

    assign bus.counter     = pc;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_instr   = out_instr_q;
    assign bus.out_pc      = out_pc_q;
    assign bus.halted      = halted_q;
    assign bus.fetch_count = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
            halted_q    <= 1'b0;
            count_q     <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            out_valid_q <= out_valid_n;
            out_instr_q <= out_instr_n;
            out_pc_q    <= out_pc_n;
            halted_q    <= halted_n;
            count_q     <= count_n;
        end
    end

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        out_valid_n = out_valid_q;
        out_instr_n = out_instr_q;
        out_pc_n    = out_pc_q;
        halted_n    = halted_q;
        count_n     = count_q;

        // A transfer in a redirect cycle still reached decode, so it is counted.
        if (xfer && (count_q != '1))
            count_n = count_q + DATA_WIDTH'(1);

        if (bus.redirect_valid) begin
            state_n     = FETCH;
            pc_n        = bus.redirect_pc & ~DATA_WIDTH'(1);
            out_valid_n = 1'b0;
            halted_n    = 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (capture) begin
                        out_instr_n = bus.instruction;
                        out_pc_n    = pc;
                        out_valid_n = 1'b1;
                        pc_n        = pc + DATA_WIDTH'(2);
                        if (bus.instruction == HALT_INSTR) begin
                            state_n  = HALTED;
                            halted_n = 1'b1;
                        end
                    end else if (xfer) begin
                        out_valid_n = 1'b0;
                    end
                end
                HALTED: begin
                    if (xfer)
                        out_valid_n = 1'b0;
                end
                default: state_n = FETCH;
            endcase
        end
    end
endmodule
